clock_monitor: RTL and testbench

CLOCK_MONITOR -- requirements
Module: clock_monitor

---
 rtl/clock_monitor_if.sv | 21 ++
 rtl/clock_monitor.sv | 103 ++++++++++
 tb/tb_clock_monitor.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_monitor_if.sv
// Signal bundle between the clock monitor and its environment.
// The slave side is the monitor; the master side drives the monitored clock and the fault clear.
interface clock_monitor_if;
  logic       clkNco;
  logic       clearFault;
  logic       ncoTick;
  logic [7:0] period;
  logic       locked;
  logic       lossPulse;
  logic       fault;

  modport master (
    output clkNco, clearFault,
    input  ncoTick, period, locked, lossPulse, fault
  );

  modport slave (
    input  clkNco, clearFault,
    output ncoTick, period, locked, lossPulse, fault
  );
endinterface

// File: rtl/clock_monitor.sv
// Measures the period of an asynchronous NCO clock in clk0 cycles and tracks lock.
// A sticky fault records any loss of lock until it is explicitly cleared.
module clock_monitor #(
  parameter int EXPECTED   = 32,
  parameter int TOL        = 1,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 64
) (
  input logic           clk0,
  input logic           rst,
  clock_monitor_if.slave bus
);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  localparam int         GW = $clog2(LOCK_COUNT + 1);
  localparam logic [7:0] LO = 8'(EXPECTED - TOL);
  localparam logic [7:0] HI = 8'(EXPECTED + TOL);
  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t          state;
  logic            sync1, sync2, sync3;
  logic [7:0]      cnt;
  logic [GW-1:0]   good_cnt;
  logic            in_tol;
  logic            timed_out;
  logic            loss;

  // A tick always beats a timeout landing in the same cycle.
  always_comb begin
    in_tol    = (cnt >= LO) && (cnt <= HI);
    timed_out = !bus.ncoTick && (cnt == TO);
    loss      = (state == LOCKED) && (bus.ncoTick ? !in_tol : timed_out);
  end

  // NOTE: every register here uses <= so each one samples pre-edge values;
  // the synchronizer chain and the period capture depend on that ordering.
  always_ff @(posedge clk0) begin
    if (rst) begin
      state         <= SEARCH;
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      sync3         <= 1'b0;
      cnt           <= 8'd0;
      good_cnt      <= '0;
      bus.ncoTick   <= 1'b0;
      bus.period    <= 8'd0;
      bus.locked    <= 1'b0;
      bus.lossPulse <= 1'b0;
      bus.fault     <= 1'b0;
    end else begin
      sync1       <= bus.clkNco;
      sync2       <= sync1;
      sync3       <= sync2;
      bus.ncoTick <= sync2 & ~sync3;

      // Reload on the tick so the value seen at the next tick is the full period.
      if (bus.ncoTick)        cnt <= 8'd1;
      else if (cnt != 8'hFF)  cnt <= cnt + 8'd1;

      bus.lossPulse <= loss;
      bus.fault     <= loss | (bus.fault & ~bus.clearFault);

      case (state)
        SEARCH: begin
          if (bus.ncoTick) begin
            state    <= TRACK;
            good_cnt <= '0;
          end
        end
        TRACK: begin
          if (bus.ncoTick) begin
            bus.period <= cnt;
            if (!in_tol) begin
              good_cnt <= '0;
            end else if (good_cnt == GW'(LOCK_COUNT - 1)) begin
              state      <= LOCKED;
              bus.locked <= 1'b1;
              good_cnt   <= '0;
            end else begin
              good_cnt <= good_cnt + GW'(1);
            end
          end else if (timed_out) begin
            state    <= SEARCH;
            good_cnt <= '0;
          end
        end
        LOCKED: begin
          if (bus.ncoTick) bus.period <= cnt;
          if (loss) begin
            state      <= SEARCH;
            bus.locked <= 1'b0;
          end
        end
        default: begin
          state      <= SEARCH;
          bus.locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_monitor.sv
// Self-checking bench for clock_monitor: directed table, hand-written corner sequences,
// and randomized clkNco/clearFault/rst traffic compared each cycle with a reference model.
module tb_clock_monitor;

  localparam int EXPECTED   = 32;
  localparam int TOL        = 1;
  localparam int LOCK_COUNT = 4;
  localparam int TIMEOUT    = 64;

  localparam int M_SEARCH = 0;
  localparam int M_TRACK  = 1;
  localparam int M_LOCKED = 2;

  logic clk0 = 1'b0;
  logic rst;

  clock_monitor_if bus ();

  clock_monitor #(
    .EXPECTED  (EXPECTED),
    .TOL       (TOL),
    .LOCK_COUNT(LOCK_COUNT),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk0(clk0),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk0 = ~clk0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: raw clkNco samples, one per clk0 edge. A tick appears two
  // edges after a sampled rise, then the period is the number of cycles between ticks.
  bit samp[$];
  bit m_tick, m_locked, m_loss, m_fault;
  int m_age, m_mode, m_good, m_period;

  task automatic model_step(input bit r, input bit c, input bit clr);
    bit tick_now, lose, ok, new_tick;
    int age;
    if (r) begin
      samp.delete();
      repeat (4) samp.push_back(1'b0);
      m_tick = 0; m_locked = 0; m_loss = 0; m_fault = 0;
      m_age = 0; m_mode = M_SEARCH; m_good = 0; m_period = 0;
      return;
    end
    tick_now = m_tick;
    age      = m_age;
    lose     = 0;
    samp.push_back(c);
    if (samp.size() > 8) void'(samp.pop_front());
    new_tick = samp[samp.size()-3] && !samp[samp.size()-4];
    m_age = tick_now ? 1 : ((age < 255) ? age + 1 : 255);
    if (tick_now) begin
      if (m_mode == M_SEARCH) begin
        m_mode = M_TRACK;
        m_good = 0;
      end else begin
        m_period = age;
        ok = (age >= EXPECTED - TOL) && (age <= EXPECTED + TOL);
        if (m_mode == M_TRACK) begin
          if (ok) begin
            m_good++;
            if (m_good == LOCK_COUNT) m_mode = M_LOCKED;
          end else begin
            m_good = 0;
          end
        end else if (!ok) begin
          m_mode = M_SEARCH;
          lose   = 1;
        end
      end
    end else if (age == TIMEOUT && m_mode != M_SEARCH) begin
      lose   = (m_mode == M_LOCKED);
      m_mode = M_SEARCH;
      m_good = 0;
    end
    m_loss   = lose;
    m_fault  = lose ? 1'b1 : (clr ? 1'b0 : m_fault);
    m_locked = (m_mode == M_LOCKED);
    m_tick   = new_tick;
  endtask

  // One clk0 cycle: inputs were set at the preceding negedge; outputs compared at the next.
  task automatic cyc();
    @(posedge clk0);
    model_step(rst, bus.clkNco, bus.clearFault);
    @(negedge clk0);
    check("m_tick",   32'(bus.ncoTick),   32'(m_tick));
    check("m_period", 32'(bus.period),    32'(m_period));
    check("m_locked", 32'(bus.locked),    32'(m_locked));
    check("m_loss",   32'(bus.lossPulse), 32'(m_loss));
    check("m_fault",  32'(bus.fault),     32'(m_fault));
  endtask

  int w_hi, w_lo, w_ph;

  task automatic set_wave(input int hi, input int lo);
    w_hi = hi; w_lo = lo; w_ph = 0;
  endtask

  task automatic nco_cyc();
    bus.clkNco = (w_ph < w_hi);
    w_ph = (w_ph + 1 == w_hi + w_lo) ? 0 : w_ph + 1;
    cyc();
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    set_wave(hi, lo);
    repeat (n * (hi + lo)) nco_cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.clkNco = 1'b0; bus.clearFault = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  typedef struct {
    int hi;
    int lo;
    int exp_period;
    bit exp_locked;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int ntick, since, lock_tick, lock_gap, per2;
    int last_tick, fall, losses, lost_at, ticks_after, relock, per_loss;
    bit fault_loss, locked_loss, clr_seen;

    // period 64 equals TIMEOUT: tick wins, so it is measured; 65 times out every time.
    vecs[0] = '{16, 16, 32, 1'b1};
    vecs[1] = '{16, 15, 31, 1'b1};
    vecs[2] = '{17, 16, 33, 1'b1};
    vecs[3] = '{17, 17, 34, 1'b0};
    vecs[4] = '{15, 15, 30, 1'b0};
    vecs[5] = '{20, 20, 40, 1'b0};
    vecs[6] = '{32, 32, 64, 1'b0};
    vecs[7] = '{33, 32,  0, 1'b0};

    rst = 1'b1; bus.clkNco = 1'b0; bus.clearFault = 1'b0;
    samp.delete();
    repeat (4) samp.push_back(1'b0);
    @(negedge clk0);
    do_reset();
    check("rst_tick",   32'(bus.ncoTick),   0);
    check("rst_period", 32'(bus.period),    0);
    check("rst_locked", 32'(bus.locked),    0);
    check("rst_loss",   32'(bus.lossPulse), 0);
    check("rst_fault",  32'(bus.fault),     0);

    for (int v = 0; v < 8; v++) begin
      do_reset();
      wave(vecs[v].hi, vecs[v].lo, 8);
      check($sformatf("tbl%0d_period", v), 32'(bus.period), vecs[v].exp_period);
      check($sformatf("tbl%0d_locked", v), 32'(bus.locked), 32'(vecs[v].exp_locked));
      check($sformatf("tbl%0d_fault",  v), 32'(bus.fault),  0);
    end

    // Ideal input: period valid from the 2nd tick, lock one cycle after the 5th.
    do_reset();
    set_wave(16, 16);
    ntick = 0; since = -1; lock_tick = 0; lock_gap = -1; per2 = -1;
    for (int i = 0; i < 400 && lock_gap < 0; i++) begin
      nco_cyc();
      if (bus.ncoTick) begin ntick++; since = 0; end
      else if (since >= 0) since++;
      if (ntick == 2 && since == 1 && per2 < 0) per2 = bus.period;
      if (bus.locked && lock_gap < 0) begin lock_tick = ntick; lock_gap = since; end
    end
    check("ideal_period2",  per2, 32);
    check("ideal_lock_tick", lock_tick, 5);
    check("ideal_lock_gap",  lock_gap, 1);
    check("ideal_fault",     32'(bus.fault), 0);

    // Stopped clock while locked.
    repeat (64) nco_cyc();
    while (w_ph != 0) nco_cyc();
    check("stop_locked_before", 32'(bus.locked), 1);
    last_tick = -1; fall = -1; losses = 0;
    for (int i = 0; i < 200; i++) begin
      if (i < 32) nco_cyc();
      else begin bus.clkNco = 1'b0; cyc(); end
      if (bus.ncoTick) last_tick = i;
      if (!bus.locked && fall < 0) fall = i;
      if (bus.lossPulse) losses++;
    end
    check("stop_fall_delay", fall - last_tick, TIMEOUT + 1);
    check("stop_loss_count", losses, 1);
    check("stop_fault_held", 32'(bus.fault), 1);
    bus.clearFault = 1'b1; cyc(); bus.clearFault = 1'b0;
    check("stop_fault_cleared", 32'(bus.fault), 0);

    // One short period while locked, then relock on ideal ticks.
    wave(16, 16, 7);
    check("short_locked_before", 32'(bus.locked), 1);
    wave(14, 14, 1);
    set_wave(16, 16);
    lost_at = -1; ticks_after = 0; relock = -1; per_loss = -1;
    fault_loss = 0; locked_loss = 1;
    for (int i = 0; i < 400 && relock < 0; i++) begin
      nco_cyc();
      if (lost_at >= 0 && bus.ncoTick) ticks_after++;
      if (bus.lossPulse && lost_at < 0) begin
        lost_at = i; per_loss = bus.period; fault_loss = bus.fault; locked_loss = bus.locked;
      end
      if (lost_at >= 0 && bus.locked && relock < 0) relock = ticks_after;
    end
    check("short_loss_seen",   32'(lost_at >= 0), 1);
    check("short_period",      per_loss, 28);
    check("short_fault",       32'(fault_loss), 1);
    check("short_locked_drop", 32'(locked_loss), 0);
    check("short_relock_ticks", relock, 5);

    // Clear fault, then a second loss with clearFault in the very same cycle.
    while (w_ph != 0) nco_cyc();
    bus.clkNco = 1'b0; bus.clearFault = 1'b1; cyc(); bus.clearFault = 1'b0;
    check("second_fault_cleared", 32'(bus.fault), 0);
    repeat (7) cyc();
    bus.clkNco = 1'b1;
    clr_seen = 0;
    for (int i = 0; i < 10; i++) begin
      bus.clearFault = m_tick;
      cyc();
      if (bus.clearFault) begin
        clr_seen = 1;
        check("second_fault_set_wins", 32'(bus.fault),     1);
        check("second_loss_pulse",     32'(bus.lossPulse), 1);
        check("second_locked_drop",    32'(bus.locked),    0);
        bus.clearFault = 1'b0;
        break;
      end
    end
    bus.clearFault = 1'b0;
    check("second_tick_seen", 32'(clr_seen), 1);

    // Reset pulse while locked, then relock at period 31.
    wave(16, 16, 7);
    check("rstlk_locked_before", 32'(bus.locked), 1);
    rst = 1'b1; cyc(); rst = 1'b0;
    check("rstlk_tick",   32'(bus.ncoTick),   0);
    check("rstlk_period", 32'(bus.period),    0);
    check("rstlk_locked", 32'(bus.locked),    0);
    check("rstlk_loss",   32'(bus.lossPulse), 0);
    check("rstlk_fault",  32'(bus.fault),     0);
    wave(16, 15, 8);
    check("rstlk_relock", 32'(bus.locked), 1);
    check("rstlk_period31", 32'(bus.period), 31);

    // Randomized traffic against the model.
    for (int p = 0; p < 400; p++) begin
      int r, hi, lo;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        hi = 0; lo = $urandom_range(40, 100);
      end else if (r < 11) begin
        hi = 16; lo = $urandom_range(15, 17);
      end else begin
        hi = $urandom_range(12, 20); lo = $urandom_range(12, 20);
      end
      for (int k = 0; k < hi + lo; k++) begin
        bus.clkNco     = (k < hi);
        bus.clearFault = ($urandom_range(0, 39) == 0);
        rst            = ($urandom_range(0, 2999) == 0);
        cyc();
      end
    end
    rst = 1'b0; bus.clearFault = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
